spdif_frame_seq: RTL
====================

Name: spdif_frame_seq

Overview:
- Sequencer/controller behind the S/PDIF receiver (spdif_dai).
- Consumes decoded subframes (24-bit audio, preamble kind, V/U/C/P bits), checks B/M/W ordering and the 192-frame block structure, and maintains a lock state.
- Pairs left/right subframes into stereo samples for the mixer via a valid/ready handshake.
- Collects the first 32 channel-status bits of each block.

Parameters:
- FRAMES_PER_BLOCK, 192, frames per channel-status block; frame counter wraps here.
- CS_BITS, 32, channel-status bits captured per block (left-channel C bits, frames 0..CS_BITS-1).
- RELOCK_BLOCKS, 1, complete clean blocks required in SYNC before LOCKED asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sf_ack_i  in  1  one-cycle strobe: subframe fields valid.
- sf_data_i  in  24  audio payload, LSB first as received.
- sf_pre_i  in  2  preamble: 0=B, 1=M, 2=W, 3=invalid.
- sf_ctl_i  in  4  {P,C,U,V} (bit3 = P).
- smp_l_o  out  24  left sample.
- smp_r_o  out  24  right sample.
- smp_valid_o  out  1  stereo pair available.
- smp_ready_i  in  1  downstream accepts when valid&ready.
- locked_o  out  1  stream locked.
- cs_o  out  CS_BITS  last complete channel-status word.
- cs_upd_o  out  1  one-cycle strobe when cs_o updates.
- err_o  out  1  one-cycle strobe on any sequence/parity/overrun error.
- ovf_cnt_o  out  8  saturating count of pairs dropped due to no ready.

Behaviour:
- Reset: all outputs 0; state=HUNT; frame counter=0; internal cs shift register=0.

States:
- HUNT: ignore everything until pre=B; then latch L, frame=0, go EXPECT_R.
- EXPECT_R: needs pre=W.
  - On W: latch R and present the pair.
  - Next state is EXPECT_L.
- EXPECT_L: needs pre=M when frame+1 < FRAMES_PER_BLOCK, or pre=B when frame+1 == FRAMES_PER_BLOCK.
  - On match: latch L; frame increments, or wraps to 0 on B.
  - Go EXPECT_R.

Errors and lock:
- Any mismatch or pre=3: err_o pulse, go HUNT, locked_o=0 on the next cycle, clean-block counter cleared, pending pair discarded.
- locked_o sets on the cycle after the RELOCK_BLOCKS-th consecutive clean B is accepted in sequence. The first B taken in HUNT does not count; with default 1, lock occurs at the start of the second block.

Output handshake:
- Pair output is a single register stage. smp_valid_o rises 1 cycle after the W strobe and holds until valid&ready.
- If a new W completes while the previous pair is unaccepted: the new pair overwrites it, valid stays 1, ovf_cnt_o increments (saturates at 255), err_o pulses. Lock is not affected.
- A W strobe in the same cycle as acceptance: no overflow; the new pair loads.
- Pairs are emitted in HUNT→EXPECT_R even before lock; consumers gate on locked_o.

Channel status:
- On each accepted left subframe with frame < CS_BITS, the C bit is shifted into bit[frame] of the shift register.
- When frame CS_BITS-1 is accepted: cs_o <= shift value (including that bit) and cs_upd_o pulses. This happens only when locked_o=1.
- A sequence error mid-block discards the partial word; cs_o retains its old value.
- sf_ack_i is never asserted on consecutive cycles (subframe spacing ≥32 clk); the block need not handle back-to-back strobes.
- rst asserted mid-pair: everything returns to reset values immediately; no partial pair is emitted.

Optional Feature:
- SPDIF_PARITY_CHECK_EN.
- Defined: each subframe must satisfy even parity over sf_data_i and sf_ctl_i (28 bits, XOR = 0). Failure is treated as a sequence error: err_o pulse, HUNT, lock lost.
- Undefined: P is ignored and there is no parity logic.

Decomposition:
- Shared package spdif_pkg: preamble codes (PRE_B/M/W/INV), sequencer state enum, ctl bit indices (CTL_V/U/C/P).
- One natural sub-module: spdif_pair_reg (one-entry output holding register with valid/ready, overwrite-on-full and overflow counter).

Test Plan:
- Reset, then B,W,M,W...: 2×192 frames with data=counter and smp_ready_i=1. Expect:
  - pairs (0,1),(2,3)…;
  - locked_o rises one cycle after the second B;
  - no err_o.
- Second block with C bit=1 on left frames 0,3,31 → cs_o=32'h80000009 and one cs_upd_o pulse, one cycle after frame 31's strobe.
- While locked, inject M where W is expected → err_o pulse, locked_o=0, no pair emitted; relock after the next B plus one clean block.
- Hold smp_ready_i=0 for 3 W strobes → smp_l_o/smp_r_o hold the latest pair, ovf_cnt_o=2, err_o pulses twice, locked_o stays 1.
- Frame 191 followed by M instead of B → error and HUNT. Separately, B at frame 100 → error.
- With SPDIF_PARITY_CHECK_EN: send data 24'h000001 with P=0 → err_o pulse and HUNT. Without the macro, the same stimulus → pair emitted normally.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared definitions for the S/PDIF frame sequencer.
//   pre_e        : preamble codes as delivered by the subframe decoder
//   seq_state_e  : sequencer position within the B/W/M/W subframe pattern
//   CTL_*        : bit positions inside the {P,C,U,V} control nibble
package spdif_pkg;

   typedef enum logic [1:0] {
      PRE_B   = 2'd0,
      PRE_M   = 2'd1,
      PRE_W   = 2'd2,
      PRE_INV = 2'd3
   } pre_e;

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_EXPECT_R = 2'd1,
      ST_EXPECT_L = 2'd2
   } seq_state_e;

   localparam int CTL_V = 0;
   localparam int CTL_U = 1;
   localparam int CTL_C = 2;
   localparam int CTL_P = 3;

   localparam int SMP_W = 24;

endpackage

// File: rtl/spdif_pair_reg.sv
// One-entry stereo pair holding register with valid/ready output.
//   clk, rst          : clock, asynchronous active-low reset
//   load, l, r        : capture a new pair (overwrites an unaccepted one)
//   flush             : drop any pending pair
//   smp_l/smp_r       : held pair, smp_valid until smp_valid & smp_ready
//   ovf_evt           : combinational, a load is overwriting an unaccepted pair
//   ovf_cnt           : saturating count of overwritten pairs
module spdif_pair_reg #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         flush,
   input  logic [W-1:0] l,
   input  logic [W-1:0] r,
   output logic [W-1:0] smp_l,
   output logic [W-1:0] smp_r,
   output logic         smp_valid,
   input  logic         smp_ready,
   output logic         ovf_evt,
   output logic [7:0]   ovf_cnt
);

   // A load in the same cycle as acceptance is not an overflow.
   assign ovf_evt = load & smp_valid & ~smp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         smp_l     <= '0;
         smp_r     <= '0;
         smp_valid <= 1'b0;
         ovf_cnt   <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         if (flush) begin
            smp_valid <= 1'b0;
         end else if (load) begin
            smp_l     <= l;
            smp_r     <= r;
            smp_valid <= 1'b1;
         end else if (smp_valid && smp_ready) begin
            smp_valid <= 1'b0;
         end
         if (ovf_evt && ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/spdif_frame_seq.sv
// S/PDIF frame sequencer: checks B/M/W preamble order and the block
// structure, tracks lock, pairs L/R subframes for the mixer and collects
// the first CS_BITS channel-status bits of each block.
// Optional feature macro: SPDIF_PARITY_CHECK_EN (even parity over data+ctl).
//   clk, rst                 : clock, asynchronous active-low reset
//   sf_ack_i                 : subframe strobe; sf_data_i/sf_pre_i/sf_ctl_i valid
//   smp_l_o/smp_r_o          : stereo pair, smp_valid_o / smp_ready_i handshake
//   locked_o                 : stream locked
//   cs_o, cs_upd_o           : last complete channel-status word, update strobe
//   err_o                    : one-cycle sequence/parity/overrun error strobe
//   ovf_cnt_o                : saturating count of dropped pairs
module spdif_frame_seq
   import spdif_pkg::*;
#(
   parameter int FRAMES_PER_BLOCK = 192,
   parameter int CS_BITS          = 32,
   parameter int RELOCK_BLOCKS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sf_ack_i,
   input  logic [SMP_W-1:0]   sf_data_i,
   input  logic [1:0]         sf_pre_i,
   input  logic [3:0]         sf_ctl_i,
   output logic [SMP_W-1:0]   smp_l_o,
   output logic [SMP_W-1:0]   smp_r_o,
   output logic               smp_valid_o,
   input  logic               smp_ready_i,
   output logic               locked_o,
   output logic [CS_BITS-1:0] cs_o,
   output logic               cs_upd_o,
   output logic               err_o,
   output logic [7:0]         ovf_cnt_o
);

   localparam int FW = $clog2(FRAMES_PER_BLOCK);
   localparam int CW = $clog2(RELOCK_BLOCKS + 1);

   seq_state_e         state_q, state_d;
   logic [FW-1:0]      frame_q, frame_d;
   logic [SMP_W-1:0]   l_q, l_d;
   logic [CS_BITS-1:0] cs_sr_q, cs_sr_d;
   logic [CS_BITS-1:0] cs_q, cs_d;
   logic               cs_upd_q, cs_upd_d;
   logic               err_q, err_d;
   logic               locked_q, locked_d;
   logic [CW-1:0]      clean_q, clean_d;

   logic               parity_ok;
   logic               seq_err;
   logic               pair_load;
   logic               take_l;
   logic [FW-1:0]      l_frame;
   logic               ovf_evt;
   logic               unused_ctl;

`ifdef SPDIF_PARITY_CHECK_EN
   assign parity_ok = ~^{sf_data_i, sf_ctl_i};
`else
   assign parity_ok = 1'b1;
`endif

   // V, U and (without parity checking) P carry nothing this block acts on.
   assign unused_ctl = ^{sf_ctl_i[CTL_P], sf_ctl_i[CTL_U], sf_ctl_i[CTL_V]};

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d   = state_q;
      frame_d   = frame_q;
      l_d       = l_q;
      cs_sr_d   = cs_sr_q;
      cs_d      = cs_q;
      cs_upd_d  = 1'b0;
      locked_d  = locked_q;
      clean_d   = clean_q;
      seq_err   = 1'b0;
      pair_load = 1'b0;
      take_l    = 1'b0;
      l_frame   = '0;

      if (sf_ack_i) begin
         unique case (state_q)
            ST_HUNT: begin
               // Anything but a clean B is silently skipped while hunting.
               if (sf_pre_i == PRE_B && parity_ok) begin
                  take_l  = 1'b1;
                  state_d = ST_EXPECT_R;
               end
            end
            ST_EXPECT_R: begin
               if (sf_pre_i == PRE_W && parity_ok) begin
                  pair_load = 1'b1;
                  state_d   = ST_EXPECT_L;
               end else begin
                  seq_err = 1'b1;
               end
            end
            ST_EXPECT_L: begin
               if (frame_q == FW'(FRAMES_PER_BLOCK - 1)) begin
                  if (sf_pre_i == PRE_B && parity_ok) begin
                     take_l  = 1'b1;
                     state_d = ST_EXPECT_R;
                     // An in-sequence B closes a clean block.
                     if (!locked_q) begin
                        if (int'(clean_q) + 1 >= RELOCK_BLOCKS) begin
                           locked_d = 1'b1;
                        end else begin
                           clean_d = clean_q + CW'(1);
                        end
                     end
                  end else begin
                     seq_err = 1'b1;
                  end
               end else begin
                  if (sf_pre_i == PRE_M && parity_ok) begin
                     take_l  = 1'b1;
                     l_frame = frame_q + FW'(1);
                     state_d = ST_EXPECT_R;
                  end else begin
                     seq_err = 1'b1;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      if (take_l) begin
         l_d     = sf_data_i;
         frame_d = l_frame;
         for (int i = 0; i < CS_BITS; i++) begin
            if (int'(l_frame) == i) begin
               cs_sr_d[i] = sf_ctl_i[CTL_C];
            end
         end
         // The published word includes the bit captured on this strobe.
         if (int'(l_frame) == CS_BITS - 1 && locked_q) begin
            cs_d     = cs_sr_d;
            cs_upd_d = 1'b1;
         end
      end

      if (seq_err) begin
         state_d  = ST_HUNT;
         frame_d  = '0;
         cs_sr_d  = '0;
         locked_d = 1'b0;
         clean_d  = '0;
      end

      err_d = seq_err | ovf_evt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_HUNT;
         frame_q  <= '0;
         l_q      <= '0;
         cs_sr_q  <= '0;
         cs_q     <= '0;
         cs_upd_q <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         clean_q  <= '0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         l_q      <= l_d;
         cs_sr_q  <= cs_sr_d;
         cs_q     <= cs_d;
         cs_upd_q <= cs_upd_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         clean_q  <= clean_d;
      end
   end

   spdif_pair_reg #(.W(SMP_W)) u_pair (
      .clk       (clk),
      .rst       (rst),
      .load      (pair_load),
      .flush     (seq_err),
      .l         (l_q),
      .r         (sf_data_i),
      .smp_l     (smp_l_o),
      .smp_r     (smp_r_o),
      .smp_valid (smp_valid_o),
      .smp_ready (smp_ready_i),
      .ovf_evt   (ovf_evt),
      .ovf_cnt   (ovf_cnt_o)
   );

   assign locked_o = locked_q;
   assign cs_o     = cs_q;
   assign cs_upd_o = cs_upd_q;
   assign err_o    = err_q;

endmodule
